piano_gpio_bridge: RTL and testbench

// - Parametrised MicroBlaze<->piano AXI_GPIO bridge; next generation of the fixed 32-bit pack/unpack wrapper around swctrl_piano.
// - Decodes the software word into registered piano controls (mode, N-note chord, sung note, compare result).
// - Filters torn multi-channel writes and queues piano note-on events in a FIFO that software drains via toggle-ack.

---
 rtl/piano_gpio_pkg.sv | 51 +++++
 rtl/piano_gpio_bridge_fifo.sv | 68 ++++++
 rtl/piano_gpio_bridge.sv | 167 ++++++++++++++++
 tb/tb_piano_gpio_bridge.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_gpio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : piano_gpio_pkg                                             |
// | Description : Shared mode encoding and gpio_i field layout helpers for   |
// |               the MicroBlaze <-> piano AXI_GPIO bridge.                  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package piano_gpio_pkg;

   typedef enum logic [1:0] {
      MODE_HOME = 2'd0,
      MODE_EAR  = 2'd1,
      MODE_FREE = 2'd2,
      MODE_RSVD = 2'd3
   } mode_e;

   localparam int MODE_W = 2;
   localparam int SUNG_W = 6;

   // gpio_i layout (LSB first): mode_sel, play_note_num, notes, sung note,
   // compare verdict, ack toggle.
   function automatic int num_w(input int max_notes);
      return $clog2(max_notes + 1);
   endfunction

   function automatic int off_num();
      return MODE_W;
   endfunction

   function automatic int off_notes(input int max_notes);
      return MODE_W + num_w(max_notes);
   endfunction

   function automatic int off_sung(input int max_notes, input int note_w);
      return off_notes(max_notes) + max_notes * note_w;
   endfunction

   function automatic int off_cmp(input int max_notes, input int note_w);
      return off_sung(max_notes, note_w) + SUNG_W;
   endfunction

   function automatic int off_ack(input int max_notes, input int note_w);
      return off_cmp(max_notes, note_w) + 1;
   endfunction

   function automatic int gpio_i_w(input int max_notes, input int note_w);
      return off_ack(max_notes, note_w) + 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/piano_gpio_bridge_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : note_evt_fifo                                              |
// | Description : Synchronous note-event FIFO with flush. Flush dominates    |
// |               push and pop; a push while full only lands when a pop      |
// |               frees a slot in the same cycle.                            |
// | Revision    : 1.0  initial release                                       |
// | Ports       : clk, rst_n (sync, active-low), flush, push, din, pop,      |
// |               full, empty, count, head                                   |
// +--------------------------------------------------------------------------+
module note_evt_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 7,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && !flush && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Pointers wrap naturally: DEPTH is a power of two.
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; consumers qualify head with empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/piano_gpio_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : piano_gpio_bridge                                          |
// | Description : MicroBlaze <-> piano AXI_GPIO bridge. Filters torn         |
// |               software writes, decodes the accepted word into piano      |
// |               controls and queues note-on events drained by toggle-ack.  |
// | Revision    : 1.0  initial release                                       |
// | Ports       : CLK100MHZ, CPU_RESETN (sync, active-low)                   |
// |               gpio_i  {ack, cmp, sung[5:0], notes, num, mode}            |
// |               gpio_o  {ovf, evt_valid, evt_note, user_controls_q}        |
// |               user_controls, note_evt_valid, note_evt_id (from piano)    |
// |               mode_sel, play_note_num/vec/mask, sung_note_id,            |
// |               compare_correct, cfg_update, evt_count (to piano)          |
// +--------------------------------------------------------------------------+
module piano_gpio_bridge
   import piano_gpio_pkg::*;
#(
   parameter int MAX_NOTES     = 3,
   parameter int NOTE_W        = 7,
   parameter int CTRL_W        = 4,
   parameter int FIFO_DEPTH    = 8,
   parameter int STABLE_CYCLES = 2,
   localparam int NUM_W        = num_w(MAX_NOTES),
   localparam int GPIO_I_W     = gpio_i_w(MAX_NOTES, NOTE_W),
   localparam int GPIO_O_W     = CTRL_W + NOTE_W + 2,
   localparam int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                        CLK100MHZ,
   input  logic                        CPU_RESETN,
   input  logic [GPIO_I_W-1:0]         gpio_i,
   output logic [GPIO_O_W-1:0]         gpio_o,
   input  logic [CTRL_W-1:0]           user_controls,
   input  logic                        note_evt_valid,
   input  logic [NOTE_W-1:0]           note_evt_id,
   output logic [1:0]                  mode_sel,
   output logic [NUM_W-1:0]            play_note_num,
   output logic [MAX_NOTES*NOTE_W-1:0] play_note_vec,
   output logic [MAX_NOTES-1:0]        play_note_mask,
   output logic [SUNG_W-1:0]           sung_note_id,
   output logic                        compare_correct,
   output logic                        cfg_update,
   output logic [CNT_W-1:0]            evt_count
);

   localparam int OFF_NUM   = off_num();
   localparam int OFF_NOTES = off_notes(MAX_NOTES);
   localparam int OFF_SUNG  = off_sung(MAX_NOTES, NOTE_W);
   localparam int OFF_CMP   = off_cmp(MAX_NOTES, NOTE_W);
   localparam int OFF_ACK   = off_ack(MAX_NOTES, NOTE_W);
   localparam int STAB_W    = $clog2(STABLE_CYCLES + 1);

   // ---------------- stability filter ----------------
   logic [GPIO_I_W-1:0] sample;
   logic [STAB_W-1:0]   stable_cnt;
   logic                accept;

   assign accept = (stable_cnt == STAB_W'(STABLE_CYCLES - 1)) && (gpio_i == sample);

   // ---------------- decode of the word being accepted ----------------
   logic [1:0]                  dec_mode;
   logic [NUM_W-1:0]            dec_num;
   logic [MAX_NOTES*NOTE_W-1:0] dec_vec;
   logic [MAX_NOTES-1:0]        dec_mask;
   logic [SUNG_W-1:0]           dec_sung;
   logic                        dec_cmp;
   logic                        dec_ack;
   logic                        dec_changed;

   always_comb begin
      dec_mode = sample[MODE_W-1:0];
      if (dec_mode == MODE_RSVD) dec_mode = MODE_HOME;
      dec_num = sample[OFF_NUM +: NUM_W];
      if (dec_num > NUM_W'(MAX_NOTES)) dec_num = NUM_W'(MAX_NOTES);
   end

   for (genvar i = 0; i < MAX_NOTES; i++) begin : g_note
      assign dec_mask[i] = (i < int'(dec_num));
      assign dec_vec[i*NOTE_W +: NOTE_W] =
         dec_mask[i] ? sample[OFF_NOTES + i*NOTE_W +: NOTE_W] : '0;
   end

   assign dec_sung = sample[OFF_SUNG +: SUNG_W];
   assign dec_cmp  = sample[OFF_CMP];
   assign dec_ack  = sample[OFF_ACK];

   // Mask is a pure function of num, so it is left out of the comparison.
   assign dec_changed = {dec_mode, dec_num, dec_vec, dec_sung, dec_cmp} !=
                        {mode_sel, play_note_num, play_note_vec, sung_note_id, compare_correct};

   // ---------------- event queue control ----------------
   logic              ack_prev;
   logic              ovf;
   logic [CTRL_W-1:0] user_controls_q;
   logic              flush;
   logic              ack_edge;
   logic              fifo_full;
   logic              fifo_empty;
   logic [NOTE_W-1:0] fifo_head;
   logic              drop_evt;

   assign flush    = accept && (dec_mode != mode_sel);
   assign ack_edge = accept && (dec_ack != ack_prev);
   // A push into a full queue survives only if a real pop frees a slot.
   assign drop_evt = note_evt_valid && fifo_full && !(ack_edge && !fifo_empty) && !flush;

   note_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (NOTE_W)
   ) u_fifo (
      .clk   (CLK100MHZ),
      .rst_n (CPU_RESETN),
      .flush (flush),
      .push  (note_evt_valid),
      .din   (note_evt_id),
      .pop   (ack_edge),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (evt_count),
      .head  (fifo_head)
   );

   assign gpio_o = {ovf, !fifo_empty, (fifo_empty ? NOTE_W'(0) : fifo_head), user_controls_q};

   // ---------------- state ----------------
   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         sample          <= '0;
         stable_cnt      <= '0;
         mode_sel        <= '0;
         play_note_num   <= '0;
         play_note_vec   <= '0;
         play_note_mask  <= '0;
         sung_note_id    <= '0;
         compare_correct <= 1'b0;
         ack_prev        <= 1'b0;
         cfg_update      <= 1'b0;
         user_controls_q <= '0;
         ovf             <= 1'b0;
      end else begin
         sample <= gpio_i;
         if (gpio_i != sample)
            stable_cnt <= '0;
         else if (stable_cnt != STAB_W'(STABLE_CYCLES))
            stable_cnt <= stable_cnt + STAB_W'(1);

         cfg_update <= accept && dec_changed;
         if (accept) begin
            mode_sel        <= dec_mode;
            play_note_num   <= dec_num;
            play_note_vec   <= dec_vec;
            play_note_mask  <= dec_mask;
            sung_note_id    <= dec_sung;
            compare_correct <= dec_cmp;
            ack_prev        <= dec_ack;
         end

         user_controls_q <= user_controls;

         if (flush)
            ovf <= 1'b0;
         else if (drop_evt)
            ovf <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_piano_gpio_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_piano_gpio_bridge                                       |
// | Description : Self-checking bench for piano_gpio_bridge (MAX_NOTES=2     |
// |               build) with a queue-based reference model.                 |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_piano_gpio_bridge;

   localparam int MAX_NOTES     = 2;
   localparam int NOTE_W        = 7;
   localparam int CTRL_W        = 4;
   localparam int FIFO_DEPTH    = 8;
   localparam int STABLE_CYCLES = 2;
   localparam int NUM_W         = $clog2(MAX_NOTES + 1);
   localparam int O_NUM         = 2;
   localparam int O_NOTES       = O_NUM + NUM_W;
   localparam int O_SUNG        = O_NOTES + MAX_NOTES * NOTE_W;
   localparam int O_CMP         = O_SUNG + 6;
   localparam int O_ACK         = O_CMP + 1;
   localparam int GI_W          = O_ACK + 1;
   localparam int GO_W          = CTRL_W + NOTE_W + 2;
   localparam int CNT_W         = $clog2(FIFO_DEPTH + 1);

   logic                        clk = 1'b0;
   logic                        rst_n;
   logic [GI_W-1:0]             gpio_i;
   logic [GO_W-1:0]             gpio_o;
   logic [CTRL_W-1:0]           user_controls;
   logic                        note_evt_valid;
   logic [NOTE_W-1:0]           note_evt_id;
   logic [1:0]                  mode_sel;
   logic [NUM_W-1:0]            play_note_num;
   logic [MAX_NOTES*NOTE_W-1:0] play_note_vec;
   logic [MAX_NOTES-1:0]        play_note_mask;
   logic [5:0]                  sung_note_id;
   logic                        compare_correct;
   logic                        cfg_update;
   logic [CNT_W-1:0]            evt_count;

   always #5 clk = ~clk;

   piano_gpio_bridge #(
      .MAX_NOTES     (MAX_NOTES),
      .NOTE_W        (NOTE_W),
      .CTRL_W        (CTRL_W),
      .FIFO_DEPTH    (FIFO_DEPTH),
      .STABLE_CYCLES (STABLE_CYCLES)
   ) dut (
      .CLK100MHZ       (clk),
      .CPU_RESETN      (rst_n),
      .gpio_i          (gpio_i),
      .gpio_o          (gpio_o),
      .user_controls   (user_controls),
      .note_evt_valid  (note_evt_valid),
      .note_evt_id     (note_evt_id),
      .mode_sel        (mode_sel),
      .play_note_num   (play_note_num),
      .play_note_vec   (play_note_vec),
      .play_note_mask  (play_note_mask),
      .sung_note_id    (sung_note_id),
      .compare_correct (compare_correct),
      .cfg_update      (cfg_update),
      .evt_count       (evt_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [GI_W-1:0]   m_prev;
   int                m_run;
   int                m_mode;
   int                m_num;
   logic [NOTE_W-1:0] m_note [MAX_NOTES];
   logic [5:0]        m_sung;
   logic              m_cmp;
   logic              m_ack;
   logic              m_cfg;
   logic              m_ovf;
   logic [CTRL_W-1:0] m_uc;
   logic [NOTE_W-1:0] q [$];

   task automatic model_edge();
      int                n_mode;
      int                n_num;
      logic [NOTE_W-1:0] n_note [MAX_NOTES];
      bit                acc, flush, pop, changed;
      if (!rst_n) begin
         m_prev = '0; m_run = 1; m_mode = 0; m_num = 0; m_sung = '0;
         m_cmp = 1'b0; m_ack = 1'b0; m_cfg = 1'b0; m_ovf = 1'b0; m_uc = '0;
         for (int i = 0; i < MAX_NOTES; i++) m_note[i] = '0;
         q.delete();
         return;
      end
      flush = 1'b0;
      pop   = 1'b0;
      // A word is taken once it has been seen on STABLE_CYCLES+1 consecutive edges.
      if (gpio_i == m_prev) begin
         if (m_run < STABLE_CYCLES + 2) m_run++;
      end else begin
         m_run = 1;
      end
      m_prev = gpio_i;
      acc    = (m_run == STABLE_CYCLES + 1);
      m_cfg  = 1'b0;
      if (acc) begin
         n_mode = int'(gpio_i[1:0]);
         if (n_mode == 3) n_mode = 0;
         n_num = int'(gpio_i[O_NUM +: NUM_W]);
         if (n_num > MAX_NOTES) n_num = MAX_NOTES;
         changed = (n_mode != m_mode) || (n_num != m_num) ||
                   (gpio_i[O_SUNG +: 6] != m_sung) || (gpio_i[O_CMP] != m_cmp);
         for (int i = 0; i < MAX_NOTES; i++) begin
            n_note[i] = (i < n_num) ? gpio_i[O_NOTES + i*NOTE_W +: NOTE_W] : '0;
            if (n_note[i] != m_note[i]) changed = 1'b1;
            m_note[i] = n_note[i];
         end
         m_cfg = changed;
         flush = (n_mode != m_mode);
         pop   = (gpio_i[O_ACK] != m_ack) && (q.size() > 0);
         m_mode = n_mode;
         m_num  = n_num;
         m_sung = gpio_i[O_SUNG +: 6];
         m_cmp  = gpio_i[O_CMP];
         m_ack  = gpio_i[O_ACK];
      end
      m_uc = user_controls;
      if (flush) begin
         q.delete();
         m_ovf = 1'b0;
      end else begin
         if (pop) void'(q.pop_front());
         if (note_evt_valid) begin
            if (q.size() < FIFO_DEPTH) q.push_back(note_evt_id);
            else m_ovf = 1'b1;
         end
      end
   endtask

   task automatic compare();
      logic [MAX_NOTES*NOTE_W-1:0] ev;
      logic [MAX_NOTES-1:0]        em;
      logic [NOTE_W-1:0]           hd;
      for (int i = 0; i < MAX_NOTES; i++) begin
         ev[i*NOTE_W +: NOTE_W] = m_note[i];
         em[i] = (i < m_num);
      end
      hd = (q.size() > 0) ? q[0] : '0;
      check("mode_sel", 64'(mode_sel), 64'(m_mode));
      check("play_note_num", 64'(play_note_num), 64'(m_num));
      check("play_note_vec", 64'(play_note_vec), 64'(ev));
      check("play_note_mask", 64'(play_note_mask), 64'(em));
      check("sung_note_id", 64'(sung_note_id), 64'(m_sung));
      check("compare_correct", 64'(compare_correct), 64'(m_cmp));
      check("cfg_update", 64'(cfg_update), 64'(m_cfg));
      check("evt_count", 64'(evt_count), 64'(q.size()));
      check("gpio_o", 64'(gpio_o), 64'({m_ovf, (q.size() > 0), hd, m_uc}));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   function automatic logic [GI_W-1:0] mk(input int mode, input int num, input int n0,
                                          input int n1, input int sung, input bit cmp,
                                          input bit ack);
      logic [GI_W-1:0] w;
      w = '0;
      w[1:0]                       = 2'(mode);
      w[O_NUM +: NUM_W]            = NUM_W'(num);
      w[O_NOTES +: NOTE_W]         = NOTE_W'(n0);
      w[O_NOTES + NOTE_W +: NOTE_W] = NOTE_W'(n1);
      w[O_SUNG +: 6]               = 6'(sung);
      w[O_CMP]                     = cmp;
      w[O_ACK]                     = ack;
      return w;
   endfunction

   task automatic hold(input logic [GI_W-1:0] w, input int n);
      gpio_i = w;
      repeat (n) tick();
   endtask

   task automatic push_evt(input int id);
      note_evt_valid = 1'b1;
      note_evt_id    = NOTE_W'(id);
      tick();
      note_evt_valid = 1'b0;
   endtask

   bit ack;

   initial begin
      rst_n = 1'b0; gpio_i = '0; user_controls = '0; note_evt_valid = 1'b0; note_evt_id = '0;
      ack = 1'b0;
      repeat (2) tick();
      check("reset_gpio_o", 64'(gpio_o), 64'(0));
      rst_n = 1'b1;

      // Held word reaches the decoded outputs on the 3rd edge, single cfg pulse.
      gpio_i = mk(2, 1, 39, 0, 0, 0, 0);
      tick(); tick();
      check("early_mode", 64'(mode_sel), 64'(0));
      tick();
      check("accept_mode", 64'(mode_sel), 64'(2));
      check("accept_vec", 64'(play_note_vec), 64'(39));
      check("accept_cfg", 64'(cfg_update), 64'(1));
      tick();
      check("cfg_single", 64'(cfg_update), 64'(0));

      // Torn writes alternating every cycle are never accepted.
      for (int k = 0; k < 10; k++) begin
         gpio_i = (k % 2 == 0) ? mk(1, 2, 10, 20, 5, 1, 0) : mk(0, 1, 30, 31, 6, 0, 0);
         tick();
         check("toggle_cfg", 64'(cfg_update), 64'(0));
      end
      check("toggle_mode", 64'(mode_sel), 64'(2));

      // Chord size clamp and masking.
      hold(mk(2, 3, 11, 22, 7, 1, 0), 4);
      check("clamp_num", 64'(play_note_num), 64'(2));
      check("clamp_mask", 64'(play_note_mask), 64'(2'b11));
      check("clamp_vec", 64'(play_note_vec), 64'({7'd22, 7'd11}));
      hold(mk(2, 1, 11, 22, 7, 1, 0), 4);
      check("mask_one", 64'(play_note_mask), 64'(2'b01));
      check("note1_zero", 64'(play_note_vec), 64'({7'd0, 7'd11}));

      // Reserved mode maps to Home; overflow; toggle-ack pop.
      hold(mk(3, 1, 11, 22, 7, 1, 0), 4);
      check("mode3_home", 64'(mode_sel), 64'(0));
      for (int k = 0; k < 9; k++) push_evt(40 + k);
      tick();
      check("ovf_count", 64'(evt_count), 64'(8));
      check("ovf_flag", 64'(gpio_o[GO_W-1]), 64'(1));
      check("ovf_head", 64'(gpio_o[CTRL_W +: NOTE_W]), 64'(40));
      ack = ~ack;
      hold(mk(3, 1, 11, 22, 7, 1, ack), 4);
      check("pop_head", 64'(gpio_o[CTRL_W +: NOTE_W]), 64'(41));
      push_evt(49);
      check("refill_count", 64'(evt_count), 64'(8));

      // Full queue: push and accepted ack on the same edge.
      ack = ~ack;
      gpio_i = mk(3, 1, 11, 22, 7, 1, ack);
      tick(); tick();
      push_evt(50);
      check("fullpp_count", 64'(evt_count), 64'(8));
      check("fullpp_ovf", 64'(gpio_o[GO_W-1]), 64'(1));
      for (int k = 0; k < 7; k++) begin
         ack = ~ack;
         hold(mk(3, 1, 11, 22, 7, 1, ack), 3);
      end
      check("tail_50", 64'(gpio_o[CTRL_W +: NOTE_W]), 64'(50));
      check("tail_count", 64'(evt_count), 64'(1));

      // Mode changes flush the queue and clear overflow.
      hold(mk(1, 1, 11, 22, 7, 1, ack), 4);
      for (int k = 0; k < 3; k++) push_evt(60 + k);
      check("pre_flush_count", 64'(evt_count), 64'(3));
      hold(mk(2, 1, 11, 22, 7, 1, ack), 4);
      check("flush_valid", 64'(gpio_o[GO_W-2]), 64'(0));
      check("flush_count", 64'(evt_count), 64'(0));
      check("flush_ovf", 64'(gpio_o[GO_W-1]), 64'(0));

      // Reset in the middle of activity.
      push_evt(70); push_evt(71);
      gpio_i = mk(1, 2, 5, 6, 9, 1, ~ack);
      user_controls = 4'hA;
      tick();
      rst_n = 1'b0; note_evt_valid = 1'b1; note_evt_id = 7'd72;
      tick();
      check("rst_gpio_o", 64'(gpio_o), 64'(0));
      check("rst_mode", 64'(mode_sel), 64'(0));
      check("rst_count", 64'(evt_count), 64'(0));
      check("rst_vec", 64'(play_note_vec), 64'(0));
      rst_n = 1'b1; note_evt_valid = 1'b0;

      // Randomized traffic against the model.
      for (int k = 0; k < 80; k++) begin
         int mode, len;
         mode = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : m_mode;
         if ($urandom_range(0, 2) == 0) ack = ~ack;
         gpio_i = mk(mode, $urandom_range(0, 3), $urandom_range(0, 127), $urandom_range(0, 127),
                     $urandom_range(0, 63), 1'($urandom_range(0, 1)), ack);
         len = $urandom_range(1, 5);
         for (int j = 0; j < len; j++) begin
            note_evt_valid = ($urandom_range(0, 2) != 0);
            note_evt_id    = NOTE_W'($urandom_range(0, 127));
            user_controls  = CTRL_W'($urandom_range(0, 15));
            rst_n          = ($urandom_range(0, 149) != 0);
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
